// File: rtl/hidden_mac_seq_if.sv
// hidden_mac_seq_if
// Bus bundle for the hidden-layer MAC sequencer: the read side of the hidden
// weight BRAM, the read side of the input-activation buffer, and the
// valid/ready result stream toward the activation/requantisation stage.
//   master : the sequencer (drives addresses and the result stream)
//   slave  : memories + downstream consumer
interface hidden_mac_seq_if #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int N_IN     = 128,
  parameter int N_HIDDEN = 64
);
  localparam int WA = $clog2((N_HIDDEN * N_IN) > 2 ? (N_HIDDEN * N_IN) : 2);
  localparam int IA = $clog2(N_IN > 2 ? N_IN : 2);
  localparam int HA = $clog2(N_HIDDEN > 2 ? N_HIDDEN : 2);

  logic        [WA-1:0]     wmem_raddr;
  logic signed [DATA_W-1:0] wmem_rdata;
  logic        [IA-1:0]     xbuf_raddr;
  logic signed [DATA_W-1:0] xbuf_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic        [HA-1:0]     out_idx;
  logic signed [ACC_W-1:0]  out_data;

  modport master (
    output wmem_raddr, xbuf_raddr, out_valid, out_idx, out_data,
    input  wmem_rdata, xbuf_rdata, out_ready
  );

  modport slave (
    input  wmem_raddr, xbuf_raddr, out_valid, out_idx, out_data,
    output wmem_rdata, xbuf_rdata, out_ready
  );
endinterface

// File: rtl/hidden_mac_seq.sv
// hidden_mac_seq
// Walks the hidden weight memory row by row together with the activation
// buffer, accumulates one signed dot product per hidden neuron and emits the
// raw sum on a valid/ready stream.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start_i     begin a full layer pass (only looked at in IDLE)
//   busy_o      high in every state except IDLE
//   done_o      one-cycle pulse at the end of a pass
//   bus         hidden_mac_seq_if.master: weight/activation read ports
//               (1-cycle registered read data) and the result stream
module hidden_mac_seq #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int N_IN     = 128,
  parameter int N_HIDDEN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  hidden_mac_seq_if.master bus
);
  localparam int WA = $clog2((N_HIDDEN * N_IN) > 2 ? (N_HIDDEN * N_IN) : 2);
  localparam int IA = $clog2(N_IN > 2 ? N_IN : 2);
  localparam int HA = $clog2(N_HIDDEN > 2 ? N_HIDDEN : 2);

  if (ACC_W < 2 * DATA_W + $clog2(N_IN)) begin : g_bad_acc_w
    $error("hidden_mac_seq: ACC_W too narrow for DATA_W/N_IN");
  end
  if (N_IN < 1 || N_HIDDEN < 1) begin : g_bad_dims
    $error("hidden_mac_seq: N_IN and N_HIDDEN must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_EMIT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic        [HA-1:0]     h_q, h_d;
  logic        [IA-1:0]     i_q, i_d;
  logic        [WA-1:0]     base_q, base_d;   // h*N_IN, advanced by adding N_IN
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     vld_q, vld_d;     // read issued last cycle -> data valid now

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = bus.wmem_rdata * bus.xbuf_rdata;
  assign prod_ext = ACC_W'(prod);   // signed cast: sign-extends

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      i_q     <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      i_q     <= i_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    i_d     = i_q;
    base_d  = base_q;
    acc_d   = vld_q ? (acc_q + prod_ext) : acc_q;
    // One issue per RUN cycle; DRAIN/EMIT never issue, so the pipe bit is
    // clear while a result is held and during the first RUN cycle of a row.
    vld_d   = (state_q == S_RUN);

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          h_d     = '0;
          i_d     = '0;
          base_d  = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_q == IA'(N_IN - 1)) state_d = S_DRAIN;
        else                      i_d     = i_q + IA'(1);
      end
      S_DRAIN: state_d = S_EMIT;
      S_EMIT: begin
        if (bus.out_ready) begin
          if (h_q == HA'(N_HIDDEN - 1)) begin
            state_d = S_DONE;
          end else begin
            h_d     = h_q + HA'(1);
            i_d     = '0;
            base_d  = base_q + WA'(N_IN);
            acc_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        // Return the address outputs to 0 for IDLE.
        h_d     = '0;
        i_d     = '0;
        base_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Addresses derive from h/i registers, so they hold outside RUN for free.
  assign bus.wmem_raddr = base_q + WA'(i_q);
  assign bus.xbuf_raddr = i_q;
  assign bus.out_valid  = (state_q == S_EMIT);
  assign bus.out_idx    = (state_q == S_EMIT) ? h_q   : '0;
  assign bus.out_data   = (state_q == S_EMIT) ? acc_q : '0;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
endmodule

// File: tb/tb_hidden_mac_seq.sv
module tb_hidden_mac_seq;
  localparam int DATA_W   = 16;
  localparam int ACC_W    = 40;
  localparam int N_IN     = 128;
  localparam int N_HIDDEN = 64;
  localparam int NW       = N_IN * N_HIDDEN;
  localparam int WA       = $clog2(NW > 2 ? NW : 2);
  localparam int IA       = $clog2(N_IN > 2 ? N_IN : 2);
  localparam int PASS_CYC = N_HIDDEN * (N_IN + 2) + 1;

  logic clk = 1'b0;
  logic rst_n, start, busy, done;
  int   checks = 0;
  int   errors = 0;

  hidden_mac_seq_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN)) bus();

  hidden_mac_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic signed [DATA_W-1:0] wmem [NW];
  logic signed [DATA_W-1:0] xmem [N_IN];
  longint                   expv [N_HIDDEN];
  int                       stall [N_HIDDEN];

  // Registered memories, one-cycle read latency.
  always @(posedge clk) begin
    bus.wmem_rdata <= wmem[bus.wmem_raddr];
    bus.xbuf_rdata <= xmem[bus.xbuf_raddr];
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"},      64'(busy),           64'(0));
    chk({nm, "_done"},      64'(done),           64'(0));
    chk({nm, "_out_valid"}, 64'(bus.out_valid),  64'(0));
    chk({nm, "_out_idx"},   64'(bus.out_idx),    64'(0));
    chk({nm, "_out_data"},  64'(bus.out_data),   64'(0));
    chk({nm, "_wmem_addr"}, 64'(bus.wmem_raddr), 64'(0));
    chk({nm, "_xbuf_addr"}, 64'(bus.xbuf_raddr), 64'(0));
  endtask

  // mode 0: random, 1: all -32768, 2: w=-32768 x=32767
  task automatic fill(input int mode);
    logic signed [DATA_W-1:0] v;
    for (int k = 0; k < NW; k++) begin
      v = DATA_W'($urandom);
      wmem[k] = (mode == 0) ? v : 16'sh8000;
    end
    for (int i = 0; i < N_IN; i++) begin
      v = DATA_W'($urandom);
      xmem[i] = (mode == 0) ? v : (mode == 1) ? 16'sh8000 : 16'sh7fff;
    end
    for (int h = 0; h < N_HIDDEN; h++) begin
      expv[h] = 0;
      for (int i = 0; i < N_IN; i++)
        expv[h] += longint'(wmem[h * N_IN + i]) * longint'(xmem[i]);
    end
  endtask

  // One layer pass against a cycle model of the documented timing.
  // poke: pulse start in RUN, EMIT and DONE. abort_h >= 0: reset mid-RUN of that neuron.
  task automatic run_pass(input string nm, input bit poke, input int abort_h);
    int h, s, c, off, left, tot, exp_done, done_at, addr_err, hold_err, proto_err, idle_err;
    tot = 0;
    for (int k = 0; k < N_HIDDEN; k++) tot += stall[k];
    exp_done = PASS_CYC + tot;
    h = 0; s = 1; left = stall[0]; done_at = -1;
    addr_err = 0; hold_err = 0; proto_err = 0; idle_err = 0;
    @(negedge clk);
    start = 1'b1;
    bus.out_ready = 1'($urandom);
    @(negedge clk);
    for (c = 1; c <= exp_done + 1; c++) begin
      off = c - s;
      start = poke && (c == 3 || c == exp_done || (h == 1 && off == N_IN + 1));
      bus.out_ready = 1'($urandom);
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (h < N_HIDDEN) begin
        if (busy !== 1'b1 || done !== 1'b0) proto_err++;
        if (h == abort_h && off == 5) begin
          start = 1'b0;
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          chk_reset_outputs({nm, "_rst"});
          @(negedge clk);
          return;
        end
        if (off < N_IN) begin
          if (bus.out_valid !== 1'b0 || bus.wmem_raddr !== WA'(h * N_IN + off) ||
              bus.xbuf_raddr !== IA'(off)) addr_err++;
        end else if (off == N_IN) begin
          if (bus.out_valid !== 1'b0 || bus.wmem_raddr !== WA'(h * N_IN + N_IN - 1) ||
              bus.xbuf_raddr !== IA'(N_IN - 1)) addr_err++;
        end else begin
          if (off == N_IN + 1) begin
            chk({nm, "_valid"}, 64'(bus.out_valid), 64'(1));
            chk({nm, "_idx"},   64'(bus.out_idx),   64'(h));
            chk({nm, "_data"},  64'(bus.out_data),  expv[h]);
          end else if (bus.out_valid !== 1'b1 || bus.out_idx !== 6'(h) ||
                       bus.out_data !== ACC_W'(expv[h])) hold_err++;
          if (bus.wmem_raddr !== WA'(h * N_IN + N_IN - 1) || bus.xbuf_raddr !== IA'(N_IN - 1))
            hold_err++;
          if (left > 0) begin
            bus.out_ready = 1'b0;
            left--;
          end else begin
            bus.out_ready = 1'b1;
            h++;
            s = c + 1;
            if (h < N_HIDDEN) left = stall[h];
          end
        end
      end else if (c == s) begin
        if (busy !== 1'b1 || bus.out_valid !== 1'b0) proto_err++;
      end else begin
        if (busy !== 1'b0 || done !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.wmem_raddr !== '0 || bus.xbuf_raddr !== '0) proto_err++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (busy !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0) idle_err++;
      @(negedge clk);
    end
    chk({nm, "_done_cycle"}, 64'(done_at),   64'(exp_done));
    chk({nm, "_addr_seq"},   64'(addr_err),  64'(0));
    chk({nm, "_emit_hold"},  64'(hold_err),  64'(0));
    chk({nm, "_protocol"},   64'(proto_err), 64'(0));
    chk({nm, "_idle_tail"},  64'(idle_err),  64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < N_HIDDEN; k++) stall[k] = 0;
    fill(0);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Random operands, no backpressure, stray start pulses.
    run_pass("rand", 1'b1, -1);

    // Five-cycle stall on neuron 1.
    fill(0);
    stall[1] = 5;
    run_pass("bp", 1'b0, -1);
    stall[1] = 0;

    // Extreme operands.
    fill(1);
    run_pass("ext_neg", 1'b0, -1);
    fill(2);
    run_pass("ext_mix", 1'b0, -1);

    // Reset during neuron 3, then a clean pass with light random backpressure.
    fill(0);
    run_pass("abort", 1'b0, 3);
    for (int k = 0; k < N_HIDDEN; k++) stall[k] = int'($urandom_range(0, 2));
    run_pass("after_rst", 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hidden_mac_seq.md
# hidden_mac_seq

Sequencer for the hidden-layer matrix-vector product. On `start`, it walks the hidden-layer weight memory row by row and the input-activation buffer in lockstep. For each hidden neuron it accumulates the signed products into one accumulator, then presents the raw sum on a valid/ready output stream. It is the read-side master of the hidden weight BRAM and sits between that memory and the activation/requantisation stage.

## Interface
- `DATA_W`, 16, width of weights and activations (signed two's complement)
- `ACC_W`, 40, accumulator width; must satisfy `ACC_W >= 2*DATA_W + $clog2(N_IN)`; elaboration error otherwise
- `N_IN`, 128, inputs per neuron (≥1)
- `N_HIDDEN`, 64, hidden neurons (≥1)
- Derived widths:
  - `WA = $clog2(max(N_HIDDEN*N_IN,2))`
  - `IA = $clog2(max(N_IN,2))`
  - `HA = $clog2(max(N_HIDDEN,2))`

Ports:
- `clk`, in, 1, clock
- `rst_n`, in, 1, reset; synchronous, active-low
- `start`, in, 1, begin a full layer pass; sampled only in IDLE
- `busy`, out, 1, high in every state except IDLE
- `done`, out, 1, one-cycle pulse when the pass completes
- `wmem_raddr`, out, WA, flattened weight address `h*N_IN+i`
- `wmem_rdata`, in, DATA_W signed, weight data; registered, 1-cycle read latency
- `xbuf_raddr`, out, IA, input activation index `i`
- `xbuf_rdata`, in, DATA_W signed, activation data; registered, 1-cycle read latency
- `out_valid`, out, 1, neuron result valid
- `out_ready`, in, 1, downstream accepts the result
- `out_idx`, out, HA, hidden neuron index of the result
- `out_data`, out, ACC_W signed, raw accumulated dot product

## Operation
- States: IDLE, RUN, DRAIN, EMIT, DONE.
- **IDLE**
  - `start`=1: clear h, i and acc; go to RUN.
  - Otherwise stay.
- **RUN**
  - Drive `wmem_raddr = h*N_IN+i` and `xbuf_raddr = i`.
  - Set the issue-valid pipe bit.
  - If i==N_IN-1, go to DRAIN; else i++.
  - The row base advances by adding N_IN, with no multiplier.
- **Accumulate**
  - Whenever the issue-valid pipe bit is set (the cycle after an issue): `acc <= acc + sext(wmem_rdata*xbuf_rdata)`.
  - The product is a full 2*DATA_W signed value, sign-extended to ACC_W.
  - No saturation is needed; the width rule guarantees no overflow.
- **DRAIN**
  - One cycle; the final product is accumulated.
  - Go to EMIT.
- **EMIT**
  - `out_valid`=1, `out_idx`=h, `out_data`=acc; all held stable until `out_ready`.
  - On `out_valid && out_ready`:
    - If h==N_HIDDEN-1, go to DONE.
    - Else h++, i=0, acc=0, go to RUN.
  - No addresses advance while stalled.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
  - `start` is ignored here.
- `start` in any non-IDLE state is ignored and has no side effect.
- Address outputs hold their last value outside RUN. In IDLE they read 0.
- Reset (any state, including mid-RUN or stalled EMIT): next cycle is IDLE, acc=0, pipe bit=0, all outputs at reset values. No partial result is emitted.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_idx`=0, `out_data`=0, `wmem_raddr`=0, `xbuf_raddr`=0.
- `start` is sampled at edge 0. RUN occupies cycles 1..N_IN, DRAIN is cycle N_IN+1, and the first EMIT is cycle N_IN+2.
- Each neuron takes N_IN+2 cycles with `out_ready` held high, plus any stall cycles.
- Full pass with no backpressure: `done` is high in cycle N_HIDDEN*(N_IN+2)+1 after start.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.
- A new `start` may be accepted the cycle after `done`.
- Weight writes through the memory's write port are not arbitrated here. The host must not write while `busy`=1.

## Test plan
- **Basic two-neuron pass.** N_IN=4, N_HIDDEN=2, all weights 1, x={1,2,3,4}, `out_ready`=1.
  - Results: idx0=10 in cycle 6, idx1=10 in cycle 12.
  - `done` in cycle 13; `busy` high cycles 1–13.
- **Default-size address sweep.** `wmem_raddr` issues 0..8191 contiguously, exactly once each. `xbuf_raddr` cycles 0..127 per neuron.
- **Backpressure.** Drop `out_ready` for 5 cycles in EMIT. `out_valid`, `out_idx` and `out_data` stay stable, no addresses change, and `done` is delayed by exactly 5 cycles.
- **Extreme operands.** N_IN=128, all weights and x = -32768. Every `out_data` = 137438953472 (2^37), with no wrap. Mixed signs (w=-32768, x=32767) give -137434759168.
- **Start handling.** `start` pulsed while in RUN, EMIT and DONE is ignored: only one pass occurs and exactly N_HIDDEN results are emitted.
- **Reset mid-operation.** `rst_n` low during RUN of neuron 3: next cycle all outputs are at reset values. A following `start` produces a clean pass beginning at `out_idx`=0 with a correct sum.
